// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants and width helper for the sprite blocks
//   SPRITE_COORD_W    default pixel coordinate width
//   SPRITE_BLOCK_LOG2 default log2 of the sprite block edge
//   SPRITE_ADDR_BASE  default constant offset of the sprite ROM address
//   clog2_min1()      ceil(log2(n)), never below 1, for counter widths
package sprite_pkg;

    localparam int SPRITE_COORD_W    = 10;
    localparam int SPRITE_BLOCK_LOG2 = 5;
    localparam int SPRITE_ADDR_BASE  = 1;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/coord_window_cmp.sv
// coord_window_cmp: one-axis window test lo <= pos < lo+SPAN plus offset pos-lo
//   pos  in   W  scan coordinate
//   lo   in   W  window start
//   hit  out  1  pos inside the window
//   off  out  W  pos - lo (meaningful only on a hit)
// The upper bound is formed at W+1 bits so a window past 2^W clips instead of wrapping.
module coord_window_cmp
    import sprite_pkg::*;
#(
    parameter int W    = SPRITE_COORD_W,
    parameter int SPAN = 32
) (
    input  logic [W-1:0] pos,
    input  logic [W-1:0] lo,
    output logic         hit,
    output logic [W-1:0] off
);

    localparam logic [W:0] SPAN_V = (W+1)'(SPAN);

    logic [W:0] hi;

    always_comb begin
        hi  = {1'b0, lo} + SPAN_V;
        hit = (pos >= lo) && ({1'b0, pos} < hi);
        off = pos - lo;
    end

endmodule

// File: rtl/sprite_strip_coord_gen.sv
// sprite_strip_coord_gen: maps the scan position onto a grid of sprite blocks (2-clock pipeline)
//   clk, reset              pixel clock, asynchronous active-high reset
//   frame_x, frame_y        current scan position
//   pix_valid, frame_start  visible-area flag, start-of-frame pulse
//   strip_x, strip_y        requested grid origin, latched on frame_start
//   strip_en                requested grid visibility, latched on frame_start
//   block_idx               col + BLOCKS_X*row of the hit block
//   inblock_addr            sprite ROM address
//   anim_frame              current animation frame
//   strip_there             current pixel lies inside the grid
// Optional macro STRIP_SCALE2X_EN draws every block at double size.
module sprite_strip_coord_gen
    import sprite_pkg::*;
#(
    parameter int COORD_W     = SPRITE_COORD_W,
    parameter int BLOCK_LOG2  = SPRITE_BLOCK_LOG2,
    parameter int BLOCKS_X    = 5,
    parameter int BLOCKS_Y    = 1,
    parameter int IDX_W       = 3,
    parameter int ANIM_FRAMES = 1,
    parameter int ANIM_DIV    = 8,
    parameter int ADDR_BASE   = SPRITE_ADDR_BASE,
    parameter int ADDR_W      = 10
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [COORD_W-1:0]                   frame_x,
    input  logic [COORD_W-1:0]                   frame_y,
    input  logic                                 pix_valid,
    input  logic                                 frame_start,
    input  logic [COORD_W-1:0]                   strip_x,
    input  logic [COORD_W-1:0]                   strip_y,
    input  logic                                 strip_en,
    output logic [IDX_W-1:0]                     block_idx,
    output logic [ADDR_W-1:0]                    inblock_addr,
    output logic [clog2_min1(ANIM_FRAMES)-1:0]   anim_frame,
    output logic                                 strip_there
);

`ifdef STRIP_SCALE2X_EN
    localparam int SC = 1;
`else
    localparam int SC = 0;
`endif

    localparam int GW  = (BLOCKS_X << BLOCK_LOG2) << SC;
    localparam int GH  = (BLOCKS_Y << BLOCK_LOG2) << SC;
    localparam int AFW = clog2_min1(ANIM_FRAMES);
    localparam int FCW = clog2_min1(ANIM_DIV);

    logic [COORD_W-1:0] sx, sy;
    logic               sen;
    logic               hx, hy;
    logic [COORD_W-1:0] ox, oy;
    logic               hit1;
    logic [COORD_W-1:0] lx1, ly1;
    logic [COORD_W-1:0] lxs, lys;
    logic [IDX_W-1:0]   idx_n;
    logic [ADDR_W-1:0]  addr_n;
    logic [FCW-1:0]     fcnt;
    logic               wrap;

    coord_window_cmp #(.W(COORD_W), .SPAN(GW)) u_cmp_x (
        .pos(frame_x),
        .lo (sx),
        .hit(hx),
        .off(ox)
    );

    coord_window_cmp #(.W(COORD_W), .SPAN(GH)) u_cmp_y (
        .pos(frame_y),
        .lo (sy),
        .hit(hy),
        .off(oy)
    );

    // Stage-2 derivation; the address picks up the animation frame current at stage 2.
    always_comb begin
        lxs    = lx1 >> SC;
        lys    = ly1 >> SC;
        idx_n  = IDX_W'(lxs >> BLOCK_LOG2) + IDX_W'(BLOCKS_X) * IDX_W'(lys >> BLOCK_LOG2);
        addr_n = ADDR_W'(ADDR_BASE)
               + ADDR_W'(lxs[BLOCK_LOG2-1:0])
               + (ADDR_W'(lys[BLOCK_LOG2-1:0]) << BLOCK_LOG2)
               + (ADDR_W'(anim_frame) << (2*BLOCK_LOG2));
        wrap   = fcnt == FCW'(ANIM_DIV-1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sx           <= '0;
            sy           <= '0;
            sen          <= 1'b0;
            fcnt         <= '0;
            anim_frame   <= '0;
            hit1         <= 1'b0;
            lx1          <= '0;
            ly1          <= '0;
            strip_there  <= 1'b0;
            block_idx    <= '0;
            inblock_addr <= '0;
        end else begin
            // Shadow copies change only between frames; the pixel on the
            // frame_start clock still compares against the old values.
            if (frame_start) begin
                sx   <= strip_x;
                sy   <= strip_y;
                sen  <= strip_en;
                fcnt <= wrap ? '0 : fcnt + 1'b1;
                if (wrap)
                    anim_frame <= (anim_frame == AFW'(ANIM_FRAMES-1)) ? '0 : anim_frame + 1'b1;
            end
            hit1        <= pix_valid & sen & hx & hy;
            lx1         <= ox;
            ly1         <= oy;
            strip_there <= hit1;
            // On a miss, index and address keep their last hit values.
            if (hit1) begin
                block_idx    <= idx_n;
                inblock_addr <= addr_n;
            end
        end
    end

endmodule

// File: tb/tb_sprite_strip_coord_gen.sv
// tb_sprite_strip_coord_gen: table-driven scoreboard bench for sprite_strip_coord_gen
module tb_sprite_strip_coord_gen;

    typedef struct {
        logic [9:0]  sx, sy;
        logic        en, fs;
        logic [9:0]  fx, fy;
        logic        pv;
        logic        chk;
        logic        there;
        logic [2:0]  idx;
        logic [9:0]  a10;
        logic [11:0] a12;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  frame_x = '0, frame_y = '0, strip_x = '0, strip_y = '0;
    logic        pix_valid = 1'b0, frame_start = 1'b0, strip_en = 1'b0;
    logic [2:0]  idx_a, idx_b;
    logic [9:0]  addr_a;
    logic [11:0] addr_b;
    logic        anim_a;
    logic [1:0]  anim_b;
    logic        there_a, there_b;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[$];
    vec_t q[$];

    always #5 clk = ~clk;

    sprite_strip_coord_gen dut_a (
        .clk(clk), .reset(reset), .frame_x(frame_x), .frame_y(frame_y),
        .pix_valid(pix_valid), .frame_start(frame_start), .strip_x(strip_x),
        .strip_y(strip_y), .strip_en(strip_en), .block_idx(idx_a),
        .inblock_addr(addr_a), .anim_frame(anim_a), .strip_there(there_a)
    );

    sprite_strip_coord_gen #(.ANIM_FRAMES(4), .ANIM_DIV(2), .ADDR_W(12)) dut_b (
        .clk(clk), .reset(reset), .frame_x(frame_x), .frame_y(frame_y),
        .pix_valid(pix_valid), .frame_start(frame_start), .strip_x(strip_x),
        .strip_y(strip_y), .strip_en(strip_en), .block_idx(idx_b),
        .inblock_addr(addr_b), .anim_frame(anim_b), .strip_there(there_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int sx, sy, en, fs, fx, fy, pv, chk_on, there, idx, a10, a12);
        vec_t v;
        v.sx = 10'(sx); v.sy = 10'(sy); v.en = 1'(en); v.fs = 1'(fs);
        v.fx = 10'(fx); v.fy = 10'(fy); v.pv = 1'(pv); v.chk = 1'(chk_on);
        v.there = 1'(there); v.idx = 3'(idx); v.a10 = 10'(a10); v.a12 = 12'(a12);
        return v;
    endfunction

    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clk);
        strip_x = v.sx; strip_y = v.sy; strip_en = v.en; frame_start = v.fs;
        frame_x = v.fx; frame_y = v.fy; pix_valid = v.pv;
        q.push_back(v);
        @(posedge clk);
        #1;
        if (q.size() == 2) begin
            e = q.pop_front();
            if (e.chk) begin
                chk($sformatf("there_a(%0d,%0d)", e.fx, e.fy), 32'(there_a), 32'(e.there));
                chk($sformatf("there_b(%0d,%0d)", e.fx, e.fy), 32'(there_b), 32'(e.there));
                if (e.there) begin
                    chk($sformatf("idx(%0d,%0d)", e.fx, e.fy), 32'(idx_a), 32'(e.idx));
                    chk($sformatf("addr10(%0d,%0d)", e.fx, e.fy), 32'(addr_a), 32'(e.a10));
                    chk($sformatf("addr12(%0d,%0d)", e.fx, e.fy), 32'(addr_b), 32'(e.a12));
                end
            end
        end
    endtask

    task automatic flush();
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " there_a"}, 32'(there_a), 0);
        chk({tag, " idx_a"}, 32'(idx_a), 0);
        chk({tag, " addr_a"}, 32'(addr_a), 0);
        chk({tag, " anim_a"}, 32'(anim_a), 0);
        chk({tag, " there_b"}, 32'(there_b), 0);
        chk({tag, " addr_b"}, 32'(addr_b), 0);
        chk({tag, " anim_b"}, 32'(anim_b), 0);
    endtask

    initial begin
        int anim_exp[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk) reset = 1'b0;

`ifndef STRIP_SCALE2X_EN
        //            sx    sy  en fs   fx   fy pv c th idx a10  a12
        tbl.push_back(mk(100, 200, 1, 1,   0,   0, 0, 1, 0, 0,  0,    0));
        tbl.push_back(mk(100, 200, 1, 0, 100, 200, 1, 1, 1, 0,  1,    1));
        tbl.push_back(mk(100, 200, 1, 0, 163, 231, 1, 1, 1, 1,  0, 1024));
        tbl.push_back(mk(100, 200, 1, 0, 260, 200, 1, 1, 0, 0,  0,    0));
        tbl.push_back(mk(100, 200, 1, 0, 259, 200, 1, 1, 1, 4, 32,   32));
        tbl.push_back(mk(100, 200, 1, 0,  99, 200, 1, 1, 0, 0,  0,    0));
        tbl.push_back(mk(100, 200, 1, 0, 100, 232, 1, 1, 0, 0,  0,    0));
        tbl.push_back(mk(100, 200, 1, 0, 130, 210, 0, 1, 0, 0,  0,    0));
        tbl.push_back(mk(300, 200, 1, 0, 100, 200, 1, 1, 1, 0,  1,    1));
        tbl.push_back(mk(300, 200, 1, 0, 300, 200, 1, 1, 0, 0,  0,    0));
        tbl.push_back(mk(300, 200, 1, 1, 120, 200, 1, 1, 1, 0, 21, 1045));
        tbl.push_back(mk(300, 200, 1, 0, 120, 200, 1, 1, 0, 0,  0,    0));
        tbl.push_back(mk(300, 200, 1, 0, 300, 200, 1, 1, 1, 0,  1, 1025));
        tbl.push_back(mk(300, 200, 1, 0, 459, 201, 1, 1, 1, 4, 64, 1088));
        tbl.push_back(mk(300, 200, 1, 0, 460, 200, 1, 1, 0, 0,  0,    0));
        tbl.push_back(mk(1000, 200, 1, 1,  0,   0, 0, 1, 0, 0,  0,    0));
        tbl.push_back(mk(1000, 200, 1, 0, 1023, 200, 1, 1, 1, 0, 24, 1048));
        tbl.push_back(mk(1000, 200, 1, 0,   0, 200, 1, 1, 0, 0,  0,    0));
        tbl.push_back(mk(1000, 200, 1, 0, 999, 200, 1, 1, 0, 0,  0,    0));
        tbl.push_back(mk(1000, 200, 0, 1,   0,   0, 0, 1, 0, 0,  0,    0));
        tbl.push_back(mk(1000, 200, 0, 0, 1010, 200, 1, 1, 0, 0,  0,    0));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
        flush();
`endif

        // Reset in the middle of a hit run, then recovery only via frame_start.
        @(negedge clk);
        strip_x = 100; strip_y = 200; strip_en = 1'b1; frame_start = 1'b1; pix_valid = 1'b0;
        @(negedge clk);
        frame_start = 1'b0; frame_x = 100; frame_y = 200; pix_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("pre-reset hit", 32'(there_a), 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_zero("async reset");
        @(negedge clk) reset = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("post-reset there_a", 32'(there_a), 0);
        chk("post-reset there_b", 32'(there_b), 0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            frame_start = 1'b0;
            chk($sformatf("anim_b[%0d]", i), 32'(anim_b), 32'(anim_exp[i]));
            chk($sformatf("anim_a[%0d]", i), 32'(anim_a), 0);
            frame_start = 1'b1;
        end
        @(negedge clk) frame_start = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("hit after frame_start", 32'(there_a), 1);

`ifdef STRIP_SCALE2X_EN
        step(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 0, 1, 0, 63, 63, 1, 1, 1, 0, 0, 2048));
        step(mk(0, 0, 1, 0, 64, 0, 1, 1, 1, 1, 1, 1025));
        step(mk(0, 0, 1, 0, 320, 0, 1, 1, 0, 0, 0, 0));
        flush();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
